// File: rtl/exec_if.sv
// Issue/writeback bundle between the issuer, the execute stage and the register file write port.
interface exec_if #(
  parameter int W = 8,
  parameter int D = 4
);
  logic         start;
  logic [2:0]   op;
  logic [D-1:0] dst;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         write_en;
  logic [D-1:0] w_addr;
  logic [W-1:0] data_out;
  logic         carry;

  modport master (
    output start, op, dst, a_in, b_in,
    input  ready, write_en, w_addr, data_out, carry
  );

  modport slave (
    input  start, op, dst, a_in, b_in,
    output ready, write_en, w_addr, data_out, carry
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit core: single-cycle ALU with registered writeback.
// Define EXEC_MUL_EN to build opcode 111 as an 8-cycle shift-add multiplier; otherwise it is MOV.
module exec_unit #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic   clk,
  input  logic   reset,
  exec_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic         write_en_q;
  logic [D-1:0] w_addr_q;
  logic [W-1:0] data_q;
  logic         carry_q;
  logic         ready;
  logic         accept;
  logic [W-1:0] alu_res;
  logic         alu_c;

  assign accept       = bus.start && ready;
  assign bus.ready    = ready;
  assign bus.write_en = write_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.data_out = data_q;
  assign bus.carry    = carry_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (bus.op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, bus.a_in} + {1'b0, bus.b_in};
      OP_SUB: begin
        alu_res = bus.a_in - bus.b_in;
        alu_c   = (bus.a_in < bus.b_in);
      end
      OP_AND:  alu_res = bus.a_in & bus.b_in;
      OP_OR:   alu_res = bus.a_in | bus.b_in;
      OP_XOR:  alu_res = bus.a_in ^ bus.b_in;
      OP_SHL:  alu_res = bus.a_in << bus.b_in[2:0];
      OP_SHR:  alu_res = bus.a_in >> bus.b_in[2:0];
      default: alu_res = bus.b_in;  // MOV when the multiplier is not built
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t         state_q;
  logic           ready_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2:0]     cnt_q;
  logic [D-1:0]   mdst_q;
  logic [2*W-1:0] acc_d;

  assign ready = ready_q;
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      write_en_q <= 1'b0;
      w_addr_q   <= '0;
      data_q     <= '0;
      carry_q    <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mdst_q     <= '0;
    end else begin
      write_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              mcand_q  <= {{W{1'b0}}, bus.a_in};
              mplier_q <= bus.b_in;
              mdst_q   <= bus.dst;
              acc_q    <= '0;
              cnt_q    <= '0;
              ready_q  <= 1'b0;
              state_q  <= S_MUL;
            end else begin
              write_en_q <= 1'b1;
              w_addr_q   <= bus.dst;
              data_q     <= alu_res;
              carry_q    <= alu_c;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 3'd1;
          // Last multiplier bit: write back and reopen issue in the same edge
          if (cnt_q == 3'd7) begin
            write_en_q <= 1'b1;
            w_addr_q   <= mdst_q;
            data_q     <= acc_d[W-1:0];
            carry_q    <= |acc_d[2*W-1:W];
            ready_q    <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
`else
  assign ready = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en_q <= 1'b0;
      w_addr_q   <= '0;
      data_q     <= '0;
      carry_q    <= 1'b0;
    end else begin
      write_en_q <= accept;
      if (accept) begin
        w_addr_q <= bus.dst;
        data_q   <= alu_res;
        carry_q  <= alu_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; MUL or MOV tests follow the EXEC_MUL_EN build.
module tb_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  exec_if #(.W(8), .D(4)) ifc ();
  exec_unit #(.W(8), .D(4)) dut (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic [2:0] op, input logic [3:0] dst,
                       input logic [7:0] a, input logic [7:0] b);
    ifc.start = s;
    ifc.op    = op;
    ifc.dst   = dst;
    ifc.a_in  = a;
    ifc.b_in  = b;
  endtask

  // observed = {ready, write_en, w_addr, data_out, carry}
  function automatic logic [14:0] obs();
    return {ifc.ready, ifc.write_en, ifc.w_addr, ifc.data_out, ifc.carry};
  endfunction

  task automatic test_reset();
    drive(1'b0, 3'd0, 4'd0, 8'h00, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_values got %h exp %h", obs(), {1'b1, 1'b0, 4'd0, 8'h00, 1'b0});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL idle_after_reset got %h exp %h", obs(), {1'b1, 1'b0, 4'd0, 8'h00, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b000, 4'd3, 8'hF0, 8'h20);
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd3, 8'h10, 1'b1}) begin
      errors++; $display("FAIL b2b_add got %h exp %h", obs(), {1'b1, 1'b1, 4'd3, 8'h10, 1'b1});
    end
    drive(1'b1, 3'b001, 4'd4, 8'h05, 8'h07);
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd4, 8'hFE, 1'b1}) begin
      errors++; $display("FAIL b2b_sub got %h exp %h", obs(), {1'b1, 1'b1, 4'd4, 8'hFE, 1'b1});
    end
    drive(1'b0, 3'b000, 4'd9, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b0, 4'd4, 8'hFE, 1'b1}) begin
      errors++; $display("FAIL b2b_hold got %h exp %h", obs(), {1'b1, 1'b0, 4'd4, 8'hFE, 1'b1});
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0]  ops [5] = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b001};
    logic [7:0]  as  [5] = '{8'hF0, 8'hF0, 8'hAA, 8'hFF, 8'h05};
    logic [7:0]  bs  [5] = '{8'h3C, 8'h0F, 8'hFF, 8'h01, 8'h05};
    logic [7:0]  exd [5] = '{8'h30, 8'hFF, 8'h55, 8'h00, 8'h00};
    logic        exc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 4'(i), as[i], bs[i]);
      @(negedge clk);
      vectors++;
      if (obs() !== {1'b1, 1'b1, 4'(i), exd[i], exc[i]}) begin
        errors++; $display("FAIL alu_op%0d got %h exp %h", i, obs(), {1'b1, 1'b1, 4'(i), exd[i], exc[i]});
      end
    end
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_shifts();
    drive(1'b1, 3'b101, 4'd7, 8'h81, 8'hF9);
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd7, 8'h02, 1'b0}) begin
      errors++; $display("FAIL shl got %h exp %h", obs(), {1'b1, 1'b1, 4'd7, 8'h02, 1'b0});
    end
    drive(1'b1, 3'b110, 4'd8, 8'h80, 8'h07);
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd8, 8'h01, 1'b0}) begin
      errors++; $display("FAIL shr got %h exp %h", obs(), {1'b1, 1'b1, 4'd8, 8'h01, 1'b0});
    end
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset_async();
    drive(1'b1, 3'b000, 4'd2, 8'h7F, 8'h90);
    @(negedge clk);
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs(), {1'b1, 1'b0, 4'd0, 8'h00, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef EXEC_MUL_EN
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [3:0] dst,
                         output logic [14:0] seen, output int cycles);
    drive(1'b1, 3'b111, dst, a, b);
    @(negedge clk);
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    cycles = 1;
    while (!ifc.write_en && cycles < 16) begin
      @(negedge clk);
      cycles++;
    end
    seen = obs();
    @(negedge clk);
  endtask

  task automatic test_mul();
    int stall_bad = 0;
    drive(1'b1, 3'b111, 4'd5, 8'h12, 8'h10);
    @(negedge clk);
    vectors++;
    if ({ifc.ready, ifc.write_en} !== 2'b00) begin
      errors++; $display("FAIL mul_e0_stall got %b exp 00", {ifc.ready, ifc.write_en});
    end
    // Competing start and operand changes while busy must be ignored
    drive(1'b1, 3'b000, 4'd9, 8'hFF, 8'hFF);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if ({ifc.ready, ifc.write_en} !== 2'b00) stall_bad++;
    end
    vectors++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL mul_stall_cycles got %0d bad exp 0", stall_bad);
    end
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd5, 8'h20, 1'b1}) begin
      errors++; $display("FAIL mul_result got %h exp %h", obs(), {1'b1, 1'b1, 4'd5, 8'h20, 1'b1});
    end
    drive(1'b1, 3'b000, 4'd6, 8'h01, 8'h02);
    @(negedge clk);
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd6, 8'h03, 1'b0}) begin
      errors++; $display("FAIL mul_then_add got %h exp %h", obs(), {1'b1, 1'b1, 4'd6, 8'h03, 1'b0});
    end
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (ifc.write_en !== 1'b0) begin
      errors++; $display("FAIL mul_single_pulse got %b exp 0", ifc.write_en);
    end
  endtask

  task automatic test_mul_bounds();
    logic [14:0] seen;
    int          cyc;
    run_mul(8'h0F, 8'h11, 4'd10, seen, cyc);
    vectors++;
    if (seen !== {1'b1, 1'b1, 4'd10, 8'hFF, 1'b0} || cyc != 9) begin
      errors++; $display("FAIL mul_0f_11 got %h after %0d exp %h after 9", seen, cyc, {1'b1, 1'b1, 4'd10, 8'hFF, 1'b0});
    end
    run_mul(8'h00, 8'hFF, 4'd0, seen, cyc);
    vectors++;
    if (seen !== {1'b1, 1'b1, 4'd0, 8'h00, 1'b0} || cyc != 9) begin
      errors++; $display("FAIL mul_00_ff got %h after %0d exp %h after 9", seen, cyc, {1'b1, 1'b1, 4'd0, 8'h00, 1'b0});
    end
    run_mul(8'hFF, 8'hFF, 4'd15, seen, cyc);
    vectors++;
    if (seen !== {1'b1, 1'b1, 4'd15, 8'h01, 1'b1} || cyc != 9) begin
      errors++; $display("FAIL mul_ff_ff got %h after %0d exp %h after 9", seen, cyc, {1'b1, 1'b1, 4'd15, 8'h01, 1'b1});
    end
  endtask

  task automatic test_reset_mid_mul();
    int pulses = 0;
    drive(1'b1, 3'b111, 4'd11, 8'h03, 8'h05);
    @(negedge clk);
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL mul_abort_reset got %h exp %h", obs(), {1'b1, 1'b0, 4'd0, 8'h00, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ifc.write_en) pulses++;
    end
    vectors++;
    if (pulses != 0 || ifc.ready !== 1'b1) begin
      errors++; $display("FAIL mul_abort_no_write got %0d pulses ready %b exp 0 pulses ready 1", pulses, ifc.ready);
    end
  endtask
`else
  task automatic test_mov();
    int not_ready = 0;
    drive(1'b1, 3'b111, 4'd12, 8'h33, 8'h44);
    @(negedge clk);
    if (ifc.ready !== 1'b1) not_ready++;
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd12, 8'h44, 1'b0}) begin
      errors++; $display("FAIL mov got %h exp %h", obs(), {1'b1, 1'b1, 4'd12, 8'h44, 1'b0});
    end
    drive(1'b1, 3'b111, 4'd13, 8'hFF, 8'h9C);
    @(negedge clk);
    if (ifc.ready !== 1'b1) not_ready++;
    vectors++;
    if (obs() !== {1'b1, 1'b1, 4'd13, 8'h9C, 1'b0}) begin
      errors++; $display("FAIL mov_b2b got %h exp %h", obs(), {1'b1, 1'b1, 4'd13, 8'h9C, 1'b0});
    end
    drive(1'b0, 3'b000, 4'd0, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifc.ready !== 1'b1) not_ready++;
    end
    vectors++;
    if (not_ready != 0 || ifc.write_en !== 1'b0) begin
      errors++; $display("FAIL mov_ready got %0d not-ready we %b exp 0 we 0", not_ready, ifc.write_en);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_logic_ops();
    test_shifts();
    test_reset_async();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_bounds();
    test_reset_mid_mul();
`else
    test_mov();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t exp finish before 100000", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the 8-bit core. It sits directly downstream of the register file: it takes the two register read ports as operands plus a decoded opcode and destination address. It produces a registered result together with the write enable and write address that drive the register file's write port. Single-cycle ALU operations issue back-to-back; an optional 8-cycle shift-add multiplier stalls issue through a ready handshake.

## Interface
- W, 8, data path width (fixed at 8)
- D, 4, register address width (matches register file pointer width)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  issue request; accepted on a rising clk edge only while ready=1
- op  input  3  opcode, sampled with start
- dst  input  D  destination register, sampled with start
- a_in  input  W  operand A (register file read port A)
- b_in  input  W  operand B (register file read port B)
- ready  output  1  unit can accept start this cycle
- write_en  output  1  one-cycle pulse: data_out/w_addr valid for register file write
- w_addr  output  D  destination register for current write
- data_out  output  W  result
- carry  output  1  carry/borrow/overflow flag of the last written result

## Operation
- Opcodes (all 8-bit, results truncated to W bits):
  - 000 ADD: a+b; carry = bit 8 of 9-bit sum
  - 001 SUB: a-b (mod 256); carry = 1 iff a<b (unsigned borrow)
  - 010 AND, 011 OR, 100 XOR: carry = 0
  - 101 SHL: a << b[2:0]; 110 SHR (logical): a >> b[2:0]; b[7:3] ignored; carry = 0
  - 111 MUL: low byte of a*b (unsigned); carry = 1 iff high byte nonzero
- FSM states: IDLE, MUL.
  - IDLE: ready=1. An accepted start with op≠111 computes and registers the result → stays IDLE. An accepted start with op=111 latches a, b and dst, clears a 16-bit accumulator and a 3-bit iteration count → MUL.
  - MUL: ready=0. Each edge processes one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand to the accumulator. After the 8th iteration, register the result and raise write_en → IDLE.
- start while ready=0 is ignored. No queuing; the issuer must hold or re-present the request.
- w_addr, data_out and carry update only on the edge that raises write_en and hold their values otherwise.
- dst has no special case; register 0 is writable.

## Timing
- Reset values: ready=1, write_en=0, w_addr=0, data_out=0, carry=0, state=IDLE, accumulator=0.
- Single-cycle op accepted at edge E0: write_en=1 with the result during the cycle after E0. write_en drops after E1 unless another op is accepted at E1. Sustained throughput is 1 op/cycle.
- MUL accepted at edge E0:
  - ready=0 from after E0 until after E8.
  - The result and write_en=1 appear after E8. ready=1 in that same cycle, so a new op can be accepted at E9.
  - Total latency is 8 cycles.
- Operands are sampled only at acceptance. Changes to a_in/b_in during MUL have no effect.
- Reset asserted mid-MUL aborts immediately. No write occurs and all outputs take their reset values.
- Read-after-write ordering: the register file commits at the edge following the write_en cycle. Hazard detection between back-to-back dependent ops belongs to control, not to this block.

## Configuration
- EXEC_MUL_EN defined: opcode 111 is the multi-cycle MUL described above, and the MUL state exists.
- EXEC_MUL_EN undefined:
  - Opcode 111 is a single-cycle MOV: data_out=b, carry=0.
  - The MUL state and accumulator are not built, and ready is constant 1.

## Test plan
- Reset mid-operation: issue MUL 3×5 and assert reset at the 4th cycle → no write_en pulse; all outputs return to reset values; ready=1.
- Back-to-back ALU: ADD a=0xF0,b=0x20,dst=3 then SUB a=0x05,b=0x07,dst=4 on consecutive cycles → write_en high for 2 cycles; (w_addr 3, data 0x10, carry 1), then (w_addr 4, data 0xFE, carry 1).
- Shifts: SHL a=0x81,b=0xF9 → data 0x02 (shift by 1, upper bits of b ignored). SHR a=0x80,b=0x07 → data 0x01. carry 0 in both cases.
- MUL with EXEC_MUL_EN: a=0x12,b=0x10,dst=5 accepted at E0 → ready low 8 cycles; start pulses meanwhile are ignored; after E8 data 0x20, carry 1, w_addr 5, a single write_en pulse.
- MUL boundary values: a=0x0F,b=0x11 → data 0xFF, carry 0. a=0,b=0xFF → data 0x00, carry 0.
- Without EXEC_MUL_EN: op 111 a=0x33,b=0x44 → data 0x44 after 1 cycle; carry 0; ready never deasserts.
